inst_fetch_resp: RTL and testbench

Instruction-memory responder for the fetch stage: accepts the fetch address and enable driven by the PC register and runs one request/acknowledge transaction per fetch on the variable-latency instruction bus. It returns the fetched word with a one-cycle valid strobe and drives `stall` back to the PC register while a fetch is outstanding. It sits between the PC register and the instruction memory / bus bridge, and feeds the IF/ID pipeline register.

---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/inst_fetch_resp_if.sv | 25 ++
 rtl/inst_fetch_resp.sv | 119 +++++++++++
 tb/tb_inst_fetch_resp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the FSM state encoding, bus widths and enable levels.
package inst_fetch_resp_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic ReadEnable  = 1'b1;
    localparam logic ReadDisable = 1'b0;

    typedef enum logic [1:0] {
        FetchIdle  = 2'd0,
        FetchWait  = 2'd1,
        FetchDrain = 2'd2
    } fetch_state_e;

    function automatic logic [InstAddrBus-1:0] word_addr(
        input logic [InstAddrBus-1:0] a
    );
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Instruction bus: one request/acknowledge transaction per fetch.
// master = fetch responder, slave = memory / bus bridge.
interface inst_fetch_resp_if;
    import inst_fetch_resp_pkg::*;

    logic                   mem_req;
    logic [InstAddrBus-1:0] mem_addr;
    logic [InstBus-1:0]     mem_rdata;
    logic                   mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/inst_fetch_resp.sv
// Fetch-stage responder: PC request -> instruction bus -> IF/ID strobe.
// Define INST_FETCH_ALIGN_CHK_EN to raise inst_adel on misaligned fetches.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter logic [InstBus-1:0] RESET_INST = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] pc,
    input  logic                   flush,
    output logic                   stall,
    inst_fetch_resp_if.master      bus,
    output logic [InstBus-1:0]     inst,
    output logic [InstAddrBus-1:0] inst_pc,
    output logic                   inst_valid,
    output logic                   inst_adel
);

    fetch_state_e           state_q, state_d;
    logic                   req_q, req_d;
    logic [InstAddrBus-1:0] addr_q, addr_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic [InstAddrBus-1:0] inst_pc_q, inst_pc_d;
    logic                   valid_q, valid_d;
    logic                   adel_q, adel_d;
    logic                   misaligned;

`ifdef INST_FETCH_ALIGN_CHK_EN
    assign misaligned = |pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = 1'b0;
        adel_d    = 1'b0;
        unique case (state_q)
            FetchIdle: begin
                if (!flush && ce == ReadEnable) begin
                    if (misaligned) begin
                        valid_d   = 1'b1;
                        adel_d    = 1'b1;
                        inst_d    = RESET_INST;
                        inst_pc_d = pc;
                    end else begin
                        req_d   = ReadEnable;
                        addr_d  = word_addr(pc);
                        pc_d    = pc;
                        state_d = FetchWait;
                    end
                end
            end
            FetchWait: begin
                // flush beats a same-cycle ack: the word is dropped
                if (bus.mem_ack) begin
                    req_d   = ReadDisable;
                    state_d = FetchIdle;
                    if (!flush) begin
                        inst_d    = bus.mem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                    end
                end else if (flush) begin
                    state_d = FetchDrain;
                end
            end
            FetchDrain: begin
                if (bus.mem_ack) begin
                    req_d   = ReadDisable;
                    state_d = FetchIdle;
                end
            end
            default: begin
                state_d = FetchIdle;
                req_d   = ReadDisable;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FetchIdle;
            req_q     <= ReadDisable;
            addr_q    <= '0;
            pc_q      <= '0;
            inst_q    <= RESET_INST;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            adel_q    <= adel_d;
        end
    end

    assign stall        = (state_q == FetchWait) || (state_q == FetchDrain);
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign inst_valid   = valid_q;
    assign inst_adel    = adel_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: vector table, directed corners, random scoreboard.
// Misaligned-fetch expectations follow INST_FETCH_ALIGN_CHK_EN.
module tb_inst_fetch_resp;
    import inst_fetch_resp_pkg::*;

    localparam logic [31:0] RST_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        flush;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_adel;

    inst_fetch_resp_if bus ();

    inst_fetch_resp #(.RESET_INST(RST_INST)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .pc         (pc),
        .flush      (flush),
        .stall      (stall),
        .bus        (bus),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_adel  (inst_adel)
    );

    always #5 clk = ~clk;

    int     n_pass  = 0;
    int     n_total = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] act_q[$];
    logic [63:0] exp_q[$];

    always @(negedge clk)
        if (inst_valid) act_q.push_back({inst, inst_pc});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch; ack in WAIT-cycle d, flush in WAIT-cycle f (-1 = none)
    task automatic run_fetch(
        input  logic [31:0] a,
        input  logic [31:0] rd,
        input  int          d,
        input  int          f,
        output logic        got_valid,
        output logic        got_adel,
        output logic [31:0] got_inst,
        output logic [31:0] got_pc,
        output int          stall_n,
        output logic        stable,
        output logic [31:0] addr_seen,
        output longint      strobe_cyc
    );
        ce              = 1'b1;
        pc              = a;
        flush           = 1'b0;
        bus.mem_ack     = 1'b0;
        step();
        ce        = 1'b0;
        pc        = $urandom;
        stall_n   = 0;
        stable    = 1'b1;
        addr_seen = bus.mem_addr;
        for (int c = 1; c <= d; c++) begin
            if (stall) stall_n++;
            if (!bus.mem_req || bus.mem_addr !== addr_seen) stable = 1'b0;
            bus.mem_ack   = (c == d);
            bus.mem_rdata = (c == d) ? rd : $urandom;
            flush         = (c == f);
            step();
        end
        bus.mem_ack = 1'b0;
        flush       = 1'b0;
        got_valid   = inst_valid;
        got_adel    = inst_adel;
        got_inst    = inst;
        got_pc      = inst_pc;
        strobe_cyc  = cyc;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          ack_cyc;
        int          flush_cyc;
        logic        exp_valid;
        int          exp_stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic        gv, ga, st;
        logic [31:0] gi, gp, ad, last_inst;
        int          sn, d, f;
        longint      sc, prev_sc;
        logic [31:0] a, rd;

        vecs[0] = '{32'h0000_0000, 32'h2408_0001, 1, -1, 1'b1, 1};
        vecs[1] = '{32'h0000_0004, 32'h2409_0002, 1, -1, 1'b1, 1};
        vecs[2] = '{32'h0000_0008, 32'h240A_0003, 1, -1, 1'b1, 1};
        vecs[3] = '{32'h0000_0010, 32'h8C01_0004, 5, -1, 1'b1, 5};
        vecs[4] = '{32'h0000_0020, 32'hDEAD_0005, 5,  2, 1'b0, 5};
        vecs[5] = '{32'h0000_0100, 32'h0000_0013, 1, -1, 1'b1, 1};
        vecs[6] = '{32'h0000_0030, 32'hBAD0_0007, 2,  2, 1'b0, 2};
        vecs[7] = '{32'h0000_0200, 32'hBAD0_0008, 3,  1, 1'b0, 3};

        rst           = 1'b1;
        ce            = 1'b0;
        flush         = 1'b0;
        pc            = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();
        chk("rst_stall", stall, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_inst", inst, RST_INST);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_adel", inst_adel, 1'b0);
        rst = 1'b0;

        last_inst = RST_INST;
        prev_sc   = 0;
        for (int i = 0; i < 8; i++) begin
            run_fetch(vecs[i].pc, vecs[i].rdata, vecs[i].ack_cyc,
                      vecs[i].flush_cyc, gv, ga, gi, gp, sn, st, ad, sc);
            chk($sformatf("v%0d_addr", i), ad, vecs[i].pc & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_req_stable", i), st, 1'b1);
            chk($sformatf("v%0d_stall_cnt", i), sn, vecs[i].exp_stall);
            chk($sformatf("v%0d_valid", i), gv, vecs[i].exp_valid);
            chk($sformatf("v%0d_adel", i), ga, 1'b0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_inst", i), gi, vecs[i].rdata);
                chk($sformatf("v%0d_inst_pc", i), gp, vecs[i].pc);
                last_inst = vecs[i].rdata;
            end else begin
                chk($sformatf("v%0d_inst_hold", i), gi, last_inst);
            end
            chk($sformatf("v%0d_stall_after", i), stall, 1'b0);
            chk($sformatf("v%0d_req_after", i), bus.mem_req, 1'b0);
            if (i == 1 || i == 2)
                chk($sformatf("v%0d_b2b_gap", i), 32'(sc - prev_sc), 32'd2);
            prev_sc = sc;
        end

        // flush together with ce in IDLE: nothing accepted
        ce    = 1'b1;
        flush = 1'b1;
        pc    = 32'h0000_0040;
        step();
        chk("flush_ce_req", bus.mem_req, 1'b0);
        chk("flush_ce_stall", stall, 1'b0);
        ce    = 1'b0;
        flush = 1'b0;
        step();
        chk("flush_ce_req2", bus.mem_req, 1'b0);

        // reset in WAIT followed by a stray ack
        ce = 1'b1;
        pc = 32'h0000_0080;
        step();
        ce = 1'b0;
        chk("mid_rst_req_pre", bus.mem_req, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_req", bus.mem_req, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ack = 1'b0;
        chk("stray_valid", inst_valid, 1'b0);
        chk("stray_inst", inst, RST_INST);
        chk("stray_inst_pc", inst_pc, 32'h0);
        chk("stray_addr", bus.mem_addr, 32'h0);
        chk("stray_stall", stall, 1'b0);
        chk("stray_req", bus.mem_req, 1'b0);
        step();
        chk("stray_valid2", inst_valid, 1'b0);

        // misaligned fetch at 0x6
`ifdef INST_FETCH_ALIGN_CHK_EN
        ce = 1'b1;
        pc = 32'h0000_0006;
        step();
        ce = 1'b0;
        chk("mis_req", bus.mem_req, 1'b0);
        chk("mis_valid", inst_valid, 1'b1);
        chk("mis_adel", inst_adel, 1'b1);
        chk("mis_inst", inst, RST_INST);
        chk("mis_inst_pc", inst_pc, 32'h0000_0006);
        chk("mis_stall", stall, 1'b0);
        step();
        chk("mis_valid_end", inst_valid, 1'b0);
`else
        run_fetch(32'h0000_0006, 32'h0000_0013, 1, -1,
                  gv, ga, gi, gp, sn, st, ad, sc);
        chk("mis_addr", ad, 32'h0000_0004);
        chk("mis_valid", gv, 1'b1);
        chk("mis_adel", ga, 1'b0);
        chk("mis_inst", gi, 32'h0000_0013);
`endif

        // random traffic against a transaction-level scoreboard
        step();
        act_q.delete();
        exp_q.delete();
        for (int i = 0; i < 150; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                flush = 1'($urandom);
                ce    = flush ? 1'($urandom) : 1'b0;
                step();
                chk("rnd_gap_req", bus.mem_req, 1'b0);
            end
            ce    = 1'b0;
            flush = 1'b0;
            d  = $urandom_range(1, 6);
            f  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, d) : -1;
            a  = $urandom & 32'hFFFF_FFFC;
            rd = $urandom;
            if (!(f >= 1 && f <= d)) exp_q.push_back({rd, a});
            run_fetch(a, rd, d, f, gv, ga, gi, gp, sn, st, ad, sc);
            chk("rnd_stall_cnt", sn, d);
            chk("rnd_req_stable", st, 1'b1);
            chk("rnd_addr", ad, a);
        end
        step();
        step();
        chk("sb_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("sb%0d_inst", i), act_q[i][63:32], exp_q[i][63:32]);
            chk($sformatf("sb%0d_pc", i), act_q[i][31:0], exp_q[i][31:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
